canvas_port_arbiter: RTL and testbench
======================================

// Module: canvas_port_arbiter
// PURPOSE
//   Owns the single read/write port (a/d/we/spo) of the 32x32 1-bit small_canvas RAM.
//   Shares it between three requesters: the recognizer read stream, the mouse stroke writer and a built-in clear engine.
//   The clear engine wipes the canvas after a recognition result or on user clear.
//   Replaces the ad-hoc canvas_read_enable address mux in top. The VGA read port (dpra/dpo) is not touched.
// PARAMETERS
//   ADDR_W        10    canvas address width (row[4:0], col[4:0])
//   DEPTH         1024  words swept by a clear; must equal 2**ADDR_W
//   STARVE_LIMIT  8     consecutive cycles a pending write may lose to reads before it is forced through
//   CLEAR_VAL     1'b0  value written by the clear engine
// PORTS
//   clk          in   1       system clock (100 MHz)
//   rst          in   1       synchronous, active-high reset
//   clear_start  in   1       one-cycle pulse: begin full-canvas clear
//   clear_busy   out  1       high while the clear sweep runs
//   clear_done   out  1       one-cycle pulse after the last clear write
//   rd_req       in   1       recognizer read request, held until rd_gnt
//   rd_addr      in   ADDR_W  read address, stable while rd_req is high
//   rd_gnt       out  1       read accepted this cycle (combinational)
//   rd_data      out  1       registered read data
//   rd_valid     out  1       rd_data valid; exactly one cycle after rd_gnt
//   wr_req       in   1       mouse write request, held until wr_gnt
//   wr_addr      in   ADDR_W  write address
//   wr_data      in   1       write data
//   wr_gnt       out  1       write performed this cycle (combinational)
//   mem_a        out  ADDR_W  to small_canvas .a
//   mem_d        out  1       to small_canvas .d
//   mem_we       out  1       to small_canvas .we
//   mem_spo      in   1       from small_canvas .spo (asynchronous read)
// BEHAVIOUR
//   Reset values: clear_busy=0, clear_done=0, rd_valid=0, rd_data=0, clear counter=0, starve counter=0, FSM=IDLE.
//   FSM states:
//     IDLE  -> CLEAR on clear_start.
//     CLEAR: mem_a=clr_cnt, mem_d=CLEAR_VAL, mem_we=1, clr_cnt+1 every cycle.
//     CLEAR -> DONE when clr_cnt==DEPTH-1 is written (DEPTH cycles total, counter then wraps to 0).
//     DONE: clear_done=1 for exactly one cycle, then IDLE. clear_busy=1 in CLEAR only.
//   Clear cost: clear_start at cycle t -> clear_busy high t+1..t+1024; clear_done at t+1025.
//   clear_start while in CLEAR or DONE: ignored; no restart, no second done pulse.
//   In CLEAR and DONE: rd_gnt=0 and wr_gnt=0. Requesters hold their requests; nothing is dropped.
//   Arbitration in IDLE, combinational, one grant per cycle:
//     only rd_req: rd_gnt=1, mem_a=rd_addr, mem_we=0.
//     only wr_req: wr_gnt=1, mem_a=wr_addr, mem_d=wr_data, mem_we=1.
//     both: read wins unless starve_cnt==STARVE_LIMIT, in which case the write wins.
//   starve_cnt: +1 each cycle wr_req is high and not granted (saturating at STARVE_LIMIT); cleared on wr_gnt or wr_req=0.
//   Read data: on rd_gnt, rd_data<=mem_spo and rd_valid<=1 on the next edge; otherwise rd_valid<=0.
//     Back-to-back rd_gnt gives one rd_valid per cycle, in order. Latency is fixed at 1.
//   Idle (no grant, not clearing): mem_we=0, mem_a=rd_addr, mem_d=0.
//   mem_we is never high in the same cycle as rd_gnt. Same-address write-then-read returns the new value.
//   rst mid-clear: sweep aborted, FSM=IDLE, no clear_done. Canvas contents left partially cleared.
//   rst asserted with rd_gnt: the pending rd_valid is suppressed.
// TESTING
//   1. rst 3 cycles -> all outputs 0. rd_req with rd_addr=10'h021 -> rd_gnt same cycle; rd_valid and mem_spo value next cycle.
//   2. clear_start at cycle 5 -> mem_we=1 with mem_a 0..1023 on cycles 6..1029. clear_done only at 1030.
//      A second clear_start at cycle 500 has no effect.
//   3. wr_req (addr 10'h3FF, data 1) during the clear -> wr_gnt stays 0 until cycle 1031, then granted.
//      Readback of 10'h3FF returns 1.
//   4. rd_req and wr_req held continuously -> reads granted for 8 cycles, write forced on cycle 9, then reads resume.
//   5. rst at sweep address 10'h200 -> clear_busy=0 next cycle, no clear_done.
//      Addresses at and above 10'h200 keep their prior data.
//   6. Write 1 to 10'h040, then read 10'h040 in the next cycle -> rd_data=1. 16 back-to-back reads -> 16 consecutive rd_valid.

Source files
------------

// File: rtl/canvas_port_arbiter.sv
// Arbiter for the single a/d/we/spo port of the 32x32 small_canvas RAM.
// Shares the port between recognizer reads, mouse writes and a full-canvas clear sweep.
module canvas_port_arbiter #(
  parameter int   ADDR_W       = 10,
  parameter int   DEPTH        = 1024,
  parameter int   STARVE_LIMIT = 8,
  parameter logic CLEAR_VAL    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear_start,
  output logic              o_clear_busy,
  output logic              o_clear_done,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_gnt,
  output logic              o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_wr_data,
  output logic              o_wr_gnt,
  output logic [ADDR_W-1:0] o_mem_a,
  output logic              o_mem_d,
  output logic              o_mem_we,
  input  logic              i_mem_spo
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [SW-1:0]     r_starve_cnt;
  logic              r_rd_data;
  logic              r_rd_valid;

  logic w_idle;
  logic w_wr_force;
  logic w_clear_wr;
  logic w_rd_gnt;
  logic w_wr_gnt;

  // NOTE: writes are gated by rst so an aborted sweep or a write coinciding with reset never lands in the RAM.
  assign w_idle     = (r_state == S_IDLE);
  assign w_wr_force = (r_starve_cnt == SW'(STARVE_LIMIT));
  assign w_clear_wr = (r_state == S_CLEAR) && !rst;
  assign w_rd_gnt   = w_idle && i_rd_req && !(i_wr_req && w_wr_force);
  assign w_wr_gnt   = w_idle && !rst && i_wr_req && (!i_rd_req || w_wr_force);

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    o_mem_a  = i_rd_addr;
    o_mem_d  = 1'b0;
    o_mem_we = 1'b0;
    if (w_clear_wr) begin
      o_mem_a  = r_clr_cnt;
      o_mem_d  = CLEAR_VAL;
      o_mem_we = 1'b1;
    end else if (w_wr_gnt) begin
      o_mem_a  = i_wr_addr;
      o_mem_d  = i_wr_data;
      o_mem_we = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_clear_start) r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == ADDR_W'(DEPTH - 1)) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Counts how long a pending write has been losing; saturates so the write stays forced.
  always_ff @(posedge clk) begin
    if (rst || !i_wr_req || w_wr_gnt) begin
      r_starve_cnt <= '0;
    end else if (!w_wr_force) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_gnt;
      if (w_rd_gnt) r_rd_data <= i_mem_spo;
    end
  end

  assign o_clear_busy = (r_state == S_CLEAR);
  assign o_clear_done = (r_state == S_DONE);
  assign o_rd_gnt     = w_rd_gnt;
  assign o_wr_gnt     = w_wr_gnt;
  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_canvas_port_arbiter.sv
// Self-checking bench for canvas_port_arbiter: RAM model, per-cycle reference model and directed scenarios.
module tb_canvas_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int LIMIT  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear_start = 1'b0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic              wr_data = 1'b0;

  logic              clear_busy, clear_done, rd_gnt, rd_data, rd_valid, wr_gnt;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_d, mem_we, mem_spo;

  int n_checks = 0;
  int n_errors = 0;

  logic ram [DEPTH];

  canvas_port_arbiter #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CLEAR_VAL(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .i_clear_start(clear_start), .o_clear_busy(clear_busy), .o_clear_done(clear_done),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_gnt(rd_gnt),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_gnt(wr_gnt),
    .o_mem_a(mem_a), .o_mem_d(mem_d), .o_mem_we(mem_we), .i_mem_spo(mem_spo)
  );

  always #5 clk = ~clk;

  // small_canvas stand-in: asynchronous read, synchronous write; preloaded with ones.
  assign mem_spo = ram[mem_a];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 1'b1;
    forever begin
      @(posedge clk);
      if (mem_we) ram[mem_a] <= mem_d;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep tracked as writes remaining, canvas shadowed separately.
  initial begin : model
    int   clr_left = 0;
    bit   done_now = 0;
    int   starve   = 0;
    bit   ev       = 0;
    bit   ed       = 0;
    bit   ref_mem [DEPTH];
    bit   busy_e, idle_e, rd_g, wr_g, we_e, d_e;
    logic [ADDR_W-1:0] a_e;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 1'b1;
    forever begin
      @(negedge clk);
      busy_e = (clr_left > 0);
      idle_e = !busy_e && !done_now;
      rd_g   = idle_e && rd_req && !(wr_req && starve >= LIMIT);
      wr_g   = idle_e && !rst && wr_req && !rd_g;
      if (busy_e && !rst) begin
        a_e = ADDR_W'(DEPTH - clr_left); d_e = 1'b0; we_e = 1'b1;
      end else if (wr_g) begin
        a_e = wr_addr; d_e = wr_data; we_e = 1'b1;
      end else begin
        a_e = rd_addr; d_e = 1'b0; we_e = 1'b0;
      end
      check("m_busy",     clear_busy, busy_e);
      check("m_done",     clear_done, done_now);
      check("m_rd_gnt",   rd_gnt,     rd_g);
      check("m_wr_gnt",   wr_gnt,     wr_g);
      check("m_rd_valid", rd_valid,   ev);
      check("m_rd_data",  rd_data,    ed);
      check("m_mem_we",   mem_we,     we_e);
      check("m_mem_a",    mem_a,      a_e);
      check("m_mem_d",    mem_d,      d_e);
      // Advance to the state after the coming edge.
      if (rst) begin
        clr_left = 0; done_now = 0; starve = 0; ev = 0; ed = 0;
      end else begin
        ev = rd_g;
        if (rd_g) ed = ref_mem[rd_addr];
        if (busy_e) begin
          clr_left--;
          done_now = (clr_left == 0);
        end else if (done_now) begin
          done_now = 0;
        end else if (clear_start) begin
          clr_left = DEPTH;
        end
        if (!wr_req || wr_g) starve = 0;
        else if (starve < LIMIT) starve++;
      end
      if (we_e) ref_mem[a_e] = d_e;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic exp, input string name);
    rd_req  = 1'b1;
    rd_addr = addr;
    tick();
    rd_req = 1'b0;
    check({name, "_valid"}, rd_valid, 1'b1);
    check(name, rd_data, exp);
  endtask

  initial begin : stim
    int k;
    int busy_cycles;
    int early_wr;
    int first_w;
    int n_rd;
    int n_valid;

    // Reset state
    repeat (3) tick();
    check("rst_busy",     clear_busy, 1'b0);
    check("rst_done",     clear_done, 1'b0);
    check("rst_rd_valid", rd_valid,   1'b0);
    check("rst_rd_data",  rd_data,    1'b0);
    check("rst_mem_we",   mem_we,     1'b0);

    // A grant during reset must not produce rd_valid
    rd_req = 1'b1; rd_addr = 10'h021; #1;
    check("rst_rd_gnt", rd_gnt, 1'b1);
    tick();
    check("rst_suppress_valid", rd_valid, 1'b0);
    rst = 1'b0; #1;
    check("rd_gnt_same_cycle", rd_gnt, 1'b1);
    tick();
    rd_req = 1'b0;
    check("rd_valid_next", rd_valid, 1'b1);
    check("rd_data_021",   rd_data,  1'b1);

    // Reset in the middle of a sweep
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    k = 0;
    while (mem_a !== 10'h200 && k < 2000) begin tick(); k++; end
    check("sweep_reaches_200", mem_a, 10'h200);
    rst = 1'b1; #1;
    check("abort_no_write", mem_we, 1'b0);
    tick();
    rst = 1'b0; #1;
    check("abort_busy_low", clear_busy, 1'b0);
    k = 0;
    repeat (20) begin if (clear_done) k++; tick(); end
    check("abort_no_done", k, 0);
    do_read(10'h1FF, 1'b0, "abort_1ff_cleared");
    do_read(10'h200, 1'b1, "abort_200_kept");
    do_read(10'h3FF, 1'b1, "abort_3ff_kept");

    // Full clear with a write waiting and a second clear_start mid-sweep
    clear_start = 1'b1; tick(); clear_start = 1'b0; #1;
    check("clr_first_a",  mem_a,      10'h000);
    check("clr_first_we", mem_we,     1'b1);
    check("clr_busy",     clear_busy, 1'b1);
    wr_req = 1'b1; wr_addr = 10'h3FF; wr_data = 1'b1;
    busy_cycles = 0; early_wr = 0; k = 0;
    while (!clear_done && k < 2000) begin
      if (clear_busy) busy_cycles++;
      if (wr_gnt) early_wr++;
      clear_start = (busy_cycles == 495);
      tick();
      k++;
    end
    clear_start = 1'b0;
    check("clr_busy_cycles", busy_cycles, 1024);
    check("clr_no_early_wr", early_wr, 0);
    check("clr_done_seen",   clear_done, 1'b1);
    check("done_wr_blocked", wr_gnt, 1'b0);
    tick();
    check("done_one_cycle",  clear_done, 1'b0);
    check("wr_after_clear",  wr_gnt, 1'b1);
    check("wr_after_a",      mem_a, 10'h3FF);
    tick();
    wr_req = 1'b0;
    do_read(10'h3FF, 1'b1, "readback_3ff");
    do_read(10'h100, 1'b0, "readback_100");

    // Starvation: both requests held
    rd_req = 1'b1; rd_addr = 10'h005;
    wr_req = 1'b1; wr_addr = 10'h006; wr_data = 1'b1; #1;
    first_w = -1; n_rd = 0;
    for (int i = 0; i < 20 && first_w < 0; i++) begin
      if (wr_gnt) first_w = i;
      else if (rd_gnt) n_rd++;
      tick();
    end
    check("starve_first_write", first_w, 8);
    check("starve_reads",       n_rd,    8);
    check("reads_resume",       rd_gnt,  1'b1);
    rd_req = 1'b0; wr_req = 1'b0;
    tick();
    do_read(10'h006, 1'b1, "forced_write_006");

    // Write then immediate read, then back-to-back reads
    wr_req = 1'b1; wr_addr = 10'h040; wr_data = 1'b1; #1;
    check("wr_only_gnt", wr_gnt, 1'b1);
    tick();
    wr_req = 1'b0;
    do_read(10'h040, 1'b1, "wr_then_rd_040");
    n_valid = 0;
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = ADDR_W'(10'h040 + i);
      tick();
      if (rd_valid) n_valid++;
    end
    rd_req = 1'b0;
    check("b2b_valid_count", n_valid, 16);
    tick();
    check("b2b_valid_drop", rd_valid, 1'b0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
